// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the CNN datapath lane logic. Used by the lane
//   dispatcher and the 1:4 PE-lane demux bench.
//   Contents:
//     LANES         number of PE lanes fed by the demux (4)
//     lane_idx_t    2-bit lane index
//     disp_state_t  dispatcher FSM states
//     onehot4()     lane index -> 4-bit one-hot demux select
//     cnt_width()   word counter width for a given burst length, min 1 bit
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int LANES = 4;

   typedef logic [1:0] lane_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } disp_state_t;

   // Lane index to demux one-hot select.
   function automatic logic [3:0] onehot4(input lane_idx_t idx);
      logic [3:0] oh;
      case (idx)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   // A burst of one word still needs a one-bit counter to stay legal.
   function automatic int cnt_width(input int burst);
      return (burst > 1) ? $clog2(burst) : 1;
   endfunction

endpackage

// File: rtl/lane_tag_counter.sv
// ---------------------------------------------------------------------------
// lane_tag_counter
//   Tracks the position of the next accepted word inside a frame: a word
//   counter 0..BURST-1 that wraps into a lane index 0..3.
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset
//     clear      in   return both counters to 0 (frame start)
//     inc        in   one word accepted; advance position
//     lane_idx   out  lane the next accepted word belongs to
//     last_word  out  next accepted word is the final word of the frame
// ---------------------------------------------------------------------------
module lane_tag_counter
   import cnn_pkg::*;
#(
   parameter int BURST = 9
)
(
   input  logic      clk,
   input  logic      reset,
   input  logic      clear,
   input  logic      inc,
   output lane_idx_t lane_idx,
   output logic      last_word
);

   localparam int            CW       = cnt_width(BURST);
   localparam logic [CW-1:0] WORD_MAX = CW'(BURST - 1);
   localparam logic [CW-1:0] WORD_ONE = CW'(1);
   localparam lane_idx_t     LANE_MAX = lane_idx_t'(LANES - 1);

   logic [CW-1:0] word_cnt_q;
   logic [CW-1:0] word_cnt_d;
   lane_idx_t     lane_idx_q;
   lane_idx_t     lane_idx_d;
   logic          burst_end_s;

   assign burst_end_s = (word_cnt_q == WORD_MAX);
   assign lane_idx    = lane_idx_q;
   assign last_word   = burst_end_s && (lane_idx_q == LANE_MAX);

   // Next-position computation; lane index wraps 3 -> 0 naturally at frame end.
   always_comb begin
      word_cnt_d = word_cnt_q;
      lane_idx_d = lane_idx_q;
      if (clear) begin
         word_cnt_d = {CW{1'b0}};
         lane_idx_d = 2'd0;
      end else if (inc) begin
         if (burst_end_s) begin
            word_cnt_d = {CW{1'b0}};
            lane_idx_d = lane_idx_q + 2'd1;
         end else begin
            word_cnt_d = word_cnt_q + WORD_ONE;
            lane_idx_d = lane_idx_q;
         end
      end else begin
         word_cnt_d = word_cnt_q;
         lane_idx_d = lane_idx_q;
      end
   end

   // Counter state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt_q <= {CW{1'b0}};
         lane_idx_q <= 2'd0;
      end else begin
         word_cnt_q <= word_cnt_d;
         lane_idx_q <= lane_idx_d;
      end
   end

endmodule

// File: rtl/lane_dispatcher.sv
// ---------------------------------------------------------------------------
// lane_dispatcher
//   Feeds the 1:4 PE-lane demux. Takes a valid/ready word stream and deals
//   it out in bursts of BURST words per lane (lane0..lane3), then ends the
//   frame. A one-entry output register holds each word with its lane tag
//   until that lane is ready.
//   Parameters:
//     size   data word width (matches the demux)
//     BURST  words per lane per frame, >= 1
//   Ports:
//     clk         in   rising-edge clock
//     reset       in   synchronous active-high reset
//     start       in   frame start pulse, honoured only in IDLE
//     in_valid    in   upstream word valid
//     in_data     in   upstream word
//     in_ready    out  word accepted when in_valid && in_ready
//     lane_ready  in   per-lane consumer ready (bit i = demux output i)
//     d_out       out  held word to demux d_in
//     sel         out  one-hot lane select while out_valid, else 0
//     out_valid   out  d_out/sel hold a word
//     busy        out  frame in progress (RUN or FLUSH)
//     done        out  one-cycle pulse after the last word transfers
// ---------------------------------------------------------------------------
module lane_dispatcher
   import cnn_pkg::*;
#(
   parameter int size  = 16,
   parameter int BURST = 9
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [size-1:0]  in_data,
   output logic             in_ready,
   input  logic [LANES-1:0] lane_ready,
   output logic [size-1:0]  d_out,
   output logic [LANES-1:0] sel,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   disp_state_t      state_q;
   disp_state_t      state_d;
   logic [size-1:0]  d_out_q;
   logic [size-1:0]  d_out_d;
   lane_idx_t        tag_q;
   lane_idx_t        tag_d;
   logic [LANES-1:0] sel_q;
   logic [LANES-1:0] sel_d;
   logic             out_valid_q;
   logic             out_valid_d;
   logic             busy_q;
   logic             busy_d;
   logic             done_q;
   logic             done_d;

   logic             xfer_s;
   logic             in_ready_s;
   logic             accept_s;
   logic             start_s;
   lane_idx_t        lane_idx_s;
   logic             last_word_s;

   // Only the tagged lane's ready matters; the others never release the word.
   assign xfer_s     = out_valid_q && lane_ready[tag_q];
   // The slot is free next cycle if empty now or draining now.
   assign in_ready_s = (state_q == ST_RUN) && (!out_valid_q || lane_ready[tag_q]);
   assign accept_s   = in_valid && in_ready_s;
   assign start_s    = (state_q == ST_IDLE) && start;

   lane_tag_counter #(
      .BURST (BURST)
   ) u_tag_cnt (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_s),
      .inc       (accept_s),
      .lane_idx  (lane_idx_s),
      .last_word (last_word_s)
   );

   // Frame sequencing; done is raised as the last held word leaves.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_s && last_word_s) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (xfer_s) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   // Output slot: a new accept overwrites a draining word in the same cycle.
   always_comb begin
      out_valid_d = out_valid_q;
      d_out_d     = d_out_q;
      tag_d       = tag_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         d_out_d     = in_data;
         tag_d       = lane_idx_s;
      end else if (xfer_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      if (out_valid_d) begin
         sel_d = onehot4(tag_d);
      end else begin
         sel_d = 4'b0000;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         d_out_q     <= {size{1'b0}};
         tag_q       <= 2'd0;
         sel_q       <= 4'b0000;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_out_q     <= d_out_d;
         tag_q       <= tag_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign d_out     = d_out_q;
   assign sel       = sel_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_lane_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_lane_dispatcher
//   Directed bench for lane_dispatcher. Two instances share the stimulus:
//   u_dut9 (BURST=9) and u_dut1 (BURST=1). Inputs change on the falling
//   edge; outputs are sampled 1 ns later. Cycle t=0 is the start cycle.
// ---------------------------------------------------------------------------
module tb_lane_dispatcher;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [15:0] in_data;
   logic [3:0]  lane_ready;

   logic        o9_in_ready, o9_out_valid, o9_busy, o9_done;
   logic [15:0] o9_d_out;
   logic [3:0]  o9_sel;
   logic        o1_in_ready, o1_out_valid, o1_busy, o1_done;
   logic [15:0] o1_d_out;
   logic [3:0]  o1_sel;

   int total = 0;
   int bad   = 0;

   lane_dispatcher #(.size(16), .BURST(9)) u_dut9 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(o9_in_ready), .lane_ready(lane_ready), .d_out(o9_d_out), .sel(o9_sel),
      .out_valid(o9_out_valid), .busy(o9_busy), .done(o9_done)
   );

   lane_dispatcher #(.size(16), .BURST(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(o1_in_ready), .lane_ready(lane_ready), .d_out(o1_d_out), .sel(o1_sel),
      .out_valid(o1_out_valid), .busy(o1_busy), .done(o1_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected demux select for the n-th word of a frame.
   function automatic logic [3:0] exp_sel(input int n, input int burst);
      logic [3:0] base;
      base = 4'b0001;
      return base << (n / burst);
   endfunction

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0000; lane_ready = 4'hF;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0000; lane_ready = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({o9_d_out, o9_sel, o9_out_valid, o9_in_ready, o9_busy, o9_done} !== 24'h0) begin
         bad++;
         $display("FAIL reset_init9: got d=%h sel=%b v=%b rdy=%b busy=%b done=%b want all 0",
                  o9_d_out, o9_sel, o9_out_valid, o9_in_ready, o9_busy, o9_done);
      end
      total++;
      if ({o1_d_out, o1_sel, o1_out_valid, o1_in_ready, o1_busy, o1_done} !== 24'h0) begin
         bad++;
         $display("FAIL reset_init1: got d=%h sel=%b v=%b want all 0", o1_d_out, o1_sel, o1_out_valid);
      end
      // Start a frame and park a word in the output slot.
      reset = 1'b0;
      @(negedge clk);
      start = 1'b1; in_valid = 1'b1; in_data = 16'h1234; lane_ready = 4'b0000;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (o9_out_valid !== 1'b1 || o9_sel !== 4'b0001 || o9_d_out !== 16'h1234) begin
         bad++;
         $display("FAIL reset_pre_held: got v=%b sel=%b d=%h want 1 0001 1234",
                  o9_out_valid, o9_sel, o9_d_out);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; lane_ready = 4'hF;
      #1;
      total++;
      if ({o9_d_out, o9_sel, o9_out_valid, o9_in_ready, o9_busy, o9_done} !== 24'h0) begin
         bad++;
         $display("FAIL reset_midrun: got d=%h sel=%b v=%b rdy=%b busy=%b done=%b want all 0",
                  o9_d_out, o9_sel, o9_out_valid, o9_in_ready, o9_busy, o9_done);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         total++;
         if (o9_done !== 1'b0 || o9_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done: cycle %0d got done=%b busy=%b want 0 0", k, o9_done, o9_busy);
         end
      end
   endtask

   task automatic test_full_frame;
      int n_x = 0, n_acc = 0, first_t = -1, done_t = -1;
      do_reset;
      for (int t = 0; t < 80 && done_t < 0; t++) begin
         @(negedge clk);
         start = (t == 0); in_valid = 1'b1; lane_ready = 4'hF; in_data = 16'h0100 + 16'(n_acc);
         #1;
         if (o9_done) done_t = t;
         if (o9_out_valid && ((o9_sel & lane_ready) != 4'b0000)) begin
            if (first_t < 0) first_t = t;
            total++;
            if (o9_sel !== exp_sel(n_x, 9) || o9_d_out !== 16'h0100 + 16'(n_x) || (t - first_t) != n_x) begin
               bad++;
               $display("FAIL frame_word%0d: got sel=%b d=%h t=%0d want sel=%b d=%h t=%0d", n_x, o9_sel,
                        o9_d_out, t, exp_sel(n_x, 9), 16'h0100 + 16'(n_x), first_t + n_x);
            end
            n_x++;
         end
         if (in_valid && o9_in_ready) n_acc++;
      end
      total++;
      if (first_t != 2 || n_x != 36 || done_t != 38) begin
         bad++;
         $display("FAIL frame_timing: got first=%0d count=%0d done=%0d want 2 36 38", first_t, n_x, done_t);
      end
      @(negedge clk);
      #1;
      total++;
      if (o9_done !== 1'b0 || o9_busy !== 1'b0 || o9_out_valid !== 1'b0 || o9_sel !== 4'b0000) begin
         bad++;
         $display("FAIL frame_after_done: got done=%b busy=%b v=%b sel=%b want 0 0 0 0000",
                  o9_done, o9_busy, o9_out_valid, o9_sel);
      end
   endtask

   task automatic test_back_pressure;
      int n_x = 0, n_acc = 0, hold = 0, done_t = -1;
      logic held;
      do_reset;
      for (int t = 0; t < 100 && done_t < 0; t++) begin
         @(negedge clk);
         start = (t == 0); in_valid = 1'b1; in_data = 16'h0200 + 16'(n_acc);
         if (n_x == 9 && o9_out_valid && hold < 5) begin
            lane_ready = 4'b1101; hold++; held = 1'b1;
         end else begin
            lane_ready = 4'hF; held = 1'b0;
         end
         #1;
         if (o9_done) done_t = t;
         if (held) begin
            total++;
            if (o9_d_out !== 16'h0209 || o9_sel !== 4'b0010 || o9_in_ready !== 1'b0) begin
               bad++;
               $display("FAIL bp_hold%0d: got d=%h sel=%b rdy=%b want 0209 0010 0", hold, o9_d_out,
                        o9_sel, o9_in_ready);
            end
         end
         if (o9_out_valid && ((o9_sel & lane_ready) != 4'b0000)) begin
            total++;
            if (o9_sel !== exp_sel(n_x, 9) || o9_d_out !== 16'h0200 + 16'(n_x)) begin
               bad++;
               $display("FAIL bp_word%0d: got sel=%b d=%h want sel=%b d=%h", n_x, o9_sel, o9_d_out,
                        exp_sel(n_x, 9), 16'h0200 + 16'(n_x));
            end
            n_x++;
         end
         if (in_valid && o9_in_ready) n_acc++;
      end
      total++;
      if (hold != 5 || n_x != 36 || done_t != 43) begin
         bad++;
         $display("FAIL bp_totals: got hold=%0d count=%0d done=%0d want 5 36 43", hold, n_x, done_t);
      end
   endtask

   task automatic test_start_ignored;
      int n_x = 0, n_acc = 0, done_t = -1;
      do_reset;
      for (int t = 0; t < 80 && done_t < 0; t++) begin
         @(negedge clk);
         start = (t == 0) || (t == 5) || (t == 37);
         in_valid = 1'b1; lane_ready = 4'hF; in_data = 16'h0400 + 16'(n_acc);
         #1;
         if (o9_done) done_t = t;
         if (t == 37) begin
            total++;
            if (o9_in_ready !== 1'b0 || o9_busy !== 1'b1) begin
               bad++;
               $display("FAIL start_flush_state: got rdy=%b busy=%b want 0 1", o9_in_ready, o9_busy);
            end
         end
         if (o9_out_valid && ((o9_sel & lane_ready) != 4'b0000)) begin
            total++;
            if (o9_sel !== exp_sel(n_x, 9) || o9_d_out !== 16'h0400 + 16'(n_x)) begin
               bad++;
               $display("FAIL start_word%0d: got sel=%b d=%h want sel=%b d=%h", n_x, o9_sel, o9_d_out,
                        exp_sel(n_x, 9), 16'h0400 + 16'(n_x));
            end
            n_x++;
         end
         if (in_valid && o9_in_ready) n_acc++;
      end
      total++;
      if (n_x != 36 || done_t != 38) begin
         bad++;
         $display("FAIL start_totals: got count=%0d done=%0d want 36 38", n_x, done_t);
      end
      start = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (o9_busy !== 1'b0) begin
         bad++;
         $display("FAIL start_flush_ignored: got busy=%b want 0", o9_busy);
      end
   endtask

   task automatic test_burst1;
      int n_x = 0, n_acc = 0, n_done = 0, done_a = -1, done_b = -1, exp_t;
      do_reset;
      for (int t = 0; t < 30 && n_done < 2; t++) begin
         @(negedge clk);
         start = (t == 0) || (o1_done && n_done == 0);
         in_valid = 1'b1; lane_ready = 4'hF; in_data = 16'h000A + 16'(n_acc);
         #1;
         if (o1_done) begin
            if (n_done == 0) done_a = t; else done_b = t;
            n_done++;
         end
         if (o1_out_valid && ((o1_sel & lane_ready) != 4'b0000)) begin
            exp_t = (n_x < 4) ? (2 + n_x) : (8 + n_x - 4);
            total++;
            if (o1_sel !== exp_sel(n_x % 4, 1) || o1_d_out !== 16'h000A + 16'(n_x) || t != exp_t) begin
               bad++;
               $display("FAIL b1_word%0d: got sel=%b d=%h t=%0d want sel=%b d=%h t=%0d", n_x, o1_sel,
                        o1_d_out, t, exp_sel(n_x % 4, 1), 16'h000A + 16'(n_x), exp_t);
            end
            n_x++;
         end
         if (in_valid && o1_in_ready) n_acc++;
      end
      total++;
      if (n_x != 8 || done_a != 6 || done_b != 12) begin
         bad++;
         $display("FAIL b1_totals: got count=%0d done1=%0d done2=%0d want 8 6 12", n_x, done_a, done_b);
      end
   endtask

   task automatic test_gaps;
      int n_x = 0, n_acc = 0;
      logic exp_v;
      do_reset;
      for (int t = 0; t < 60 && n_x < 12; t++) begin
         @(negedge clk);
         start = (t == 0); lane_ready = 4'hF; in_data = 16'h0300 + 16'(n_acc);
         in_valid = (t >= 1) && ((t - 1) % 3 == 0);
         exp_v = (t >= 2) && ((t - 2) % 3 == 0);
         #1;
         total++;
         if (o9_out_valid !== exp_v || (!o9_out_valid && o9_sel !== 4'b0000) || o9_in_ready !== (t >= 1)) begin
            bad++;
            $display("FAIL gap_cycle%0d: got v=%b sel=%b rdy=%b want v=%b rdy=%b", t, o9_out_valid,
                     o9_sel, o9_in_ready, exp_v, (t >= 1));
         end
         if (o9_out_valid && ((o9_sel & lane_ready) != 4'b0000)) begin
            total++;
            if (o9_sel !== exp_sel(n_x, 9) || o9_d_out !== 16'h0300 + 16'(n_x)) begin
               bad++;
               $display("FAIL gap_word%0d: got sel=%b d=%h want sel=%b d=%h", n_x, o9_sel, o9_d_out,
                        exp_sel(n_x, 9), 16'h0300 + 16'(n_x));
            end
            if (n_x == 9) begin
               total++;
               if (o9_sel !== 4'b0010) begin
                  bad++;
                  $display("FAIL gap_word9_lane1: got sel=%b want 0010", o9_sel);
               end
            end
            n_x++;
         end
         if (in_valid && o9_in_ready) n_acc++;
      end
      total++;
      if (n_x != 12) begin
         bad++;
         $display("FAIL gap_count: got %0d want 12", n_x);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0000; lane_ready = 4'hF;
      test_reset;
      test_full_frame;
      test_back_pressure;
      test_start_ignored;
      test_burst1;
      test_gaps;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
